// File: rtl/gpu_stencil_cache_banked.sv
// Banked stencil store: 2^BANK_BITS banks, masked writes via a read-modify-write cycle,
// 1-cycle reads, and a bulk-clear engine that fills every bank in parallel.

module gpu_stencil_bank #(
    parameter int ROW_W  = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              a_we,
    input  logic              a_re,
    input  logic [ROW_W-1:0]  a_row,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_q,
    input  logic              b_re,
    input  logic [ROW_W-1:0]  b_row,
    output logic [DATA_W-1:0] b_q
);
    logic [DATA_W-1:0] mem [2**ROW_W];

    // Port A is the write side; it also fetches the old word for a merge.
    always_ff @(posedge clk_i) begin
        if (a_we) mem[a_row] <= a_wdata;
        if (a_re) a_q <= mem[a_row];
    end

    // Port B output register holds until the next read of this bank (read-first vs port A).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   b_q <= '0;
        else if (b_re) b_q <= mem[b_row];
    end
endmodule

module gpu_stencil_cache_banked #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int BANK_BITS = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_req_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_mask_i,
    input  logic [DATA_W-1:0] wr_value_i,
    input  logic              rd_req_i,
    output logic              rd_ready_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_value_o,
    input  logic              clr_req_i,
    input  logic [DATA_W-1:0] clr_value_i,
    output logic              clr_busy_o,
    output logic              clr_done_o
);
    localparam int NUM_BANKS = 1 << BANK_BITS;
    localparam int ROW_W     = ADDR_W - BANK_BITS;
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;

    typedef enum logic [1:0] {IDLE, MERGE, CLEAR, DONE} state_t;
    state_t state, state_nx;

    logic [BANK_W-1:0] wr_bank, rd_bank, rd_bank_q, rmw_bank;
    logic [ROW_W-1:0]  wr_row, rd_row, rmw_row, clr_cnt, a_row;
    logic [DATA_W-1:0] rmw_mask, rmw_val, clr_val_q;
    logic              wr_acc, rd_acc, wr_full;

    logic [NUM_BANKS-1:0]             a_we, a_re, b_re;
    logic [NUM_BANKS-1:0][DATA_W-1:0] a_wdata, a_q, b_q;

    generate
        if (BANK_BITS > 0) begin : g_bank_sel
            assign wr_bank = wr_addr_i[BANK_BITS-1:0];
            assign rd_bank = rd_addr_i[BANK_BITS-1:0];
        end else begin : g_one_bank
            assign wr_bank = '0;
            assign rd_bank = '0;
        end
    endgenerate
    assign wr_row = wr_addr_i[ADDR_W-1:BANK_BITS];
    assign rd_row = rd_addr_i[ADDR_W-1:BANK_BITS];

    assign wr_full = &wr_mask_i;
    assign wr_acc  = wr_req_i & wr_ready_o;
    assign rd_acc  = rd_req_i & rd_ready_o;

    always_comb begin
        state_nx   = state;
        wr_ready_o = 1'b0;
        rd_ready_o = 1'b0;
        clr_busy_o = 1'b0;
        clr_done_o = 1'b0;
        case (state)
            IDLE: begin
                // Clear wins over a write in the same cycle.
                wr_ready_o = !clr_req_i;
                rd_ready_o = 1'b1;
                if (clr_req_i)                state_nx = CLEAR;
                else if (wr_req_i && !wr_full) state_nx = MERGE;
            end
            MERGE: begin
                rd_ready_o = !((rd_row == rmw_row) && (rd_bank == rmw_bank));
                state_nx   = IDLE;
            end
            CLEAR: begin
                clr_busy_o = 1'b1;
                if (clr_cnt == '1) state_nx = DONE;
            end
            DONE: begin
                clr_done_o = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clr_val_q  <= '0;
            rmw_bank   <= '0;
            rmw_row    <= '0;
            rmw_mask   <= '0;
            rmw_val    <= '0;
            rd_valid_o <= 1'b0;
            rd_bank_q  <= '0;
        end else begin
            state      <= state_nx;
            rd_valid_o <= rd_acc;
            if (rd_acc) rd_bank_q <= rd_bank;
            if (state == IDLE && clr_req_i) begin
                clr_cnt   <= '0;
                clr_val_q <= clr_value_i;
            end else if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (wr_acc && !wr_full) begin
                rmw_bank <= wr_bank;
                rmw_row  <= wr_row;
                rmw_mask <= wr_mask_i;
                rmw_val  <= wr_value_i;
            end
        end
    end

    assign a_row = (state == CLEAR) ? clr_cnt : (state == MERGE) ? rmw_row : wr_row;

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign a_we[b] = (wr_acc && wr_full && wr_bank == BANK_W'(b))
                           || (state == MERGE && rmw_bank == BANK_W'(b))
                           || (state == CLEAR);
            assign a_re[b] = wr_acc && !wr_full && wr_bank == BANK_W'(b);
            assign b_re[b] = rd_acc && rd_bank == BANK_W'(b);
            assign a_wdata[b] = (state == CLEAR) ? clr_val_q
                              : (state == MERGE) ? ((rmw_val & rmw_mask) | (a_q[b] & ~rmw_mask))
                              : wr_value_i;

            gpu_stencil_bank #(.ROW_W(ROW_W), .DATA_W(DATA_W)) u_bank (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .a_we    (a_we[b]),
                .a_re    (a_re[b]),
                .a_row   (a_row),
                .a_wdata (a_wdata[b]),
                .a_q     (a_q[b]),
                .b_re    (b_re[b]),
                .b_row   (rd_row),
                .b_q     (b_q[b])
            );
        end
    endgenerate

    assign rd_value_o = b_q[rd_bank_q];
endmodule

// File: tb/tb_gpu_stencil_cache_banked.sv
// Directed bench for gpu_stencil_cache_banked: inputs driven on the falling edge,
// outputs sampled on the falling edge (or #1 after driving for combinational readies).

module tb_gpu_stencil_cache_banked;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        wr_req_i, wr_ready_o;
    logic [14:0] wr_addr_i, rd_addr_i;
    logic [15:0] wr_mask_i, wr_value_i, rd_value_o, clr_value_i;
    logic        rd_req_i, rd_ready_o, rd_valid_o;
    logic        clr_req_i, clr_busy_o, clr_done_o;

    int checks = 0;
    int errors = 0;

    gpu_stencil_cache_banked dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_req_i    (wr_req_i),
        .wr_ready_o  (wr_ready_o),
        .wr_addr_i   (wr_addr_i),
        .wr_mask_i   (wr_mask_i),
        .wr_value_i  (wr_value_i),
        .rd_req_i    (rd_req_i),
        .rd_ready_o  (rd_ready_o),
        .rd_addr_i   (rd_addr_i),
        .rd_valid_o  (rd_valid_o),
        .rd_value_o  (rd_value_o),
        .clr_req_i   (clr_req_i),
        .clr_value_i (clr_value_i),
        .clr_busy_o  (clr_busy_o),
        .clr_done_o  (clr_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for wr_ready, then holds the request across one accepting edge.
    task automatic wr(input logic [14:0] addr, input logic [15:0] mask, input logic [15:0] val);
        int n;
        @(negedge clk_i);
        wr_req_i = 1'b1; wr_addr_i = addr; wr_mask_i = mask; wr_value_i = val;
        #1;
        n = 0;
        while (!wr_ready_o && n < 50) begin
            @(negedge clk_i); #1; n++;
        end
        if (n == 50) chk("wr_ready_timeout", 0, 1);
        @(negedge clk_i);
        wr_req_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [14:0] addr, input logic [15:0] exp);
        @(negedge clk_i);
        rd_req_i = 1'b1; rd_addr_i = addr;
        @(negedge clk_i);
        rd_req_i = 1'b0;
        chk({tag, "_valid"}, rd_valid_o, 1);
        chk({tag, "_data"}, rd_value_o, exp);
    endtask

    initial begin
        int busy_cnt;
        bit done_seen;
        logic [14:0] clr_addrs [5] = '{15'h0005, 15'h0012, 15'h7FFF, 15'h1234, 15'h0100};

        rst_ni = 1'b0;
        wr_req_i = 0; wr_addr_i = 0; wr_mask_i = 0; wr_value_i = 0;
        rd_req_i = 0; rd_addr_i = 0; clr_req_i = 0; clr_value_i = 0;
        #12;
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_rd_value", rd_value_o, 0);
        chk("rst_busy", clr_busy_o, 0);
        chk("rst_done", clr_done_o, 0);
        chk("rst_wr_ready", wr_ready_o, 1);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_rd_ready", rd_ready_o, 1);

        // 1: full write then read
        wr(15'h0005, 16'hFFFF, 16'hA5A5);
        rd("t1", 15'h0005, 16'hA5A5);
        @(negedge clk_i);
        chk("t1_valid_pulse", rd_valid_o, 0);
        chk("t1_value_hold", rd_value_o, 16'hA5A5);

        // 2: partial write merge, ready drops for exactly the merge cycle
        wr(15'h0012, 16'hFFFF, 16'hFF00);
        @(negedge clk_i);
        wr_req_i = 1; wr_addr_i = 15'h0012; wr_mask_i = 16'h00F0; wr_value_i = 16'h1234;
        #1 chk("t2_ready_idle", wr_ready_o, 1);
        @(negedge clk_i);
        wr_req_i = 0;
        #1 chk("t2_ready_merge", wr_ready_o, 0);
        @(negedge clk_i);
        #1 chk("t2_ready_back", wr_ready_o, 1);
        rd("t2", 15'h0012, 16'hFF30);

        // 3: read stall only for the address under merge
        wr(15'h0040, 16'hFFFF, 16'h7777);
        wr(15'h0041, 16'hFFFF, 16'h2222);
        @(negedge clk_i);
        wr_req_i = 1; wr_addr_i = 15'h0040; wr_mask_i = 16'h000F; wr_value_i = 16'h0005;
        @(negedge clk_i);
        wr_req_i = 0;
        rd_req_i = 1; rd_addr_i = 15'h0040;
        #1 chk("t3_rd_stall", rd_ready_o, 0);
        rd_addr_i = 15'h0041;
        #1 chk("t3_rd_other", rd_ready_o, 1);
        @(negedge clk_i);
        rd_req_i = 0;
        chk("t3_other_valid", rd_valid_o, 1);
        chk("t3_other_data", rd_value_o, 16'h2222);
        rd("t3_merged", 15'h0040, 16'h7775);

        // back-to-back partial writes: second sees the first's merge
        wr(15'h0060, 16'hFFFF, 16'h0000);
        wr(15'h0060, 16'h000F, 16'hFFFF);
        wr(15'h0060, 16'hF000, 16'hFFFF);
        rd("b2b", 15'h0060, 16'hF00F);

        // 4: same-cycle read/write is read-first
        wr(15'h0100, 16'hFFFF, 16'h1111);
        @(negedge clk_i);
        wr_req_i = 1; wr_addr_i = 15'h0100; wr_mask_i = 16'hFFFF; wr_value_i = 16'hBEEF;
        rd_req_i = 1; rd_addr_i = 15'h0100;
        @(negedge clk_i);
        wr_req_i = 0; rd_req_i = 0;
        chk("t4_old", rd_value_o, 16'h1111);
        rd("t4_new", 15'h0100, 16'hBEEF);

        // mask all zeros keeps the stored word
        wr(15'h0200, 16'hFFFF, 16'h5A5A);
        wr(15'h0200, 16'h0000, 16'hFFFF);
        rd("mask0", 15'h0200, 16'h5A5A);

        // 5: bulk clear
        @(negedge clk_i);
        clr_req_i = 1; clr_value_i = 16'h0F0F; wr_req_i = 1; wr_addr_i = 15'h0005;
        wr_mask_i = 16'hFFFF; wr_value_i = 16'hDEAD;
        #1 chk("t5_wr_blocked", wr_ready_o, 0);
        busy_cnt = 0; done_seen = 0;
        for (int i = 0; i < 5000 && !done_seen; i++) begin
            @(negedge clk_i);
            wr_req_i = 0;
            if (clr_busy_o) busy_cnt++;
            if (i == 10) chk("t5_rd_blocked", rd_ready_o, 0);
            if (clr_done_o) begin
                done_seen = 1;
                clr_req_i = 0;
                chk("t5_busy_at_done", clr_busy_o, 0);
            end
        end
        chk("t5_done_seen", done_seen, 1);
        chk("t5_busy_cycles", busy_cnt, 4096);
        @(negedge clk_i);
        chk("t5_done_pulse", clr_done_o, 0);
        chk("t5_idle_busy", clr_busy_o, 0);
        foreach (clr_addrs[k]) rd("t5_fill", clr_addrs[k], 16'h0F0F);

        // 6: reset mid-clear at counter 100
        @(negedge clk_i);
        clr_req_i = 1; clr_value_i = 16'hAAAA;
        busy_cnt = 0;
        for (int i = 0; i < 300 && busy_cnt < 101; i++) begin
            @(negedge clk_i);
            if (clr_busy_o) busy_cnt++;
        end
        chk("t6_reached_100", busy_cnt, 101);
        rst_ni = 0; clr_req_i = 0;
        #1;
        chk("t6_busy_rst", clr_busy_o, 0);
        chk("t6_valid_rst", rd_valid_o, 0);
        chk("t6_done_rst", clr_done_o, 0);
        @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);
        chk("t6_busy_after", clr_busy_o, 0);
        chk("t6_wr_ready", wr_ready_o, 1);
        chk("t6_rd_ready", rd_ready_o, 1);
        wr(15'h0033, 16'hFFFF, 16'hC3C3);
        rd("t6_post", 15'h0033, 16'hC3C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
